jt12_slot_sched: RTL and testbench

JT12_SLOT_SCHED -- requirements
Module: jt12_slot_sched

---
 rtl/jt12_sched_pkg.sv | 13 +
 rtl/jt12_pcm_buf.sv | 37 +++
 rtl/jt12_slot_sched.sv | 74 +++++++
 tb/tb_jt12_slot_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/jt12_sched_pkg.sv
// jt12_sched_pkg: slot/channel constants, operator-group boundaries and group decode shared by the slot scheduler
package jt12_sched_pkg;
  localparam int SLOTS        = 24;
  localparam int CHANNELS     = 6;
  localparam int S1_LAST      = 5;
  localparam int S3_LAST      = 11;
  localparam int S2_LAST      = 17;
  localparam int CONSUME_SLOT = 11;
  typedef enum logic [1:0] {GRP_S1, GRP_S3, GRP_S2, GRP_S4} grp_e;
  function automatic grp_e grp_of(logic [4:0] s);
    return s <= 5'(S1_LAST) ? GRP_S1 : s <= 5'(S3_LAST) ? GRP_S3 : s <= 5'(S2_LAST) ? GRP_S2 : GRP_S4;
  endfunction
endpackage

// File: rtl/jt12_pcm_buf.sv
// jt12_pcm_buf: PCM sample buffer, 1 entry by default, 2-entry FIFO with JT12_PCM_FIFO_EN
// ports: wr/din push a sample (dropped when full unless rd pops in the same cycle),
// rd pops the oldest entry (ignored when empty), dout = oldest entry, full/empty = occupancy flags
module jt12_pcm_buf #(parameter int PCM_W = 9) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             rd,
  input  logic [PCM_W-1:0] din,
  output logic [PCM_W-1:0] dout,
  output logic             full,
  output logic             empty
);
`ifdef JT12_PCM_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic [PCM_W-1:0] mem [DEPTH];
  logic [1:0] cnt;
  logic pop, push;
  assign empty = cnt == 2'd0;
  assign full  = cnt == 2'(DEPTH);
  assign dout  = mem[0];
  assign pop   = rd && !empty;
  // a pop in the same cycle frees a slot, so a write into a full buffer is kept
  assign push  = wr && (!full || pop);
  // mem[0] is always the oldest entry; pops shift the rest down
  always_ff @(posedge clk) begin
    if (rst) cnt <= 2'd0;
    else cnt <= cnt + 2'(push) - 2'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (push && i == int'(cnt) - int'(pop)) mem[i] <= din;
      else if (pop && i < DEPTH - 1) mem[i] <= mem[(i + 1) % DEPTH];
    end
  end
endmodule

// File: rtl/jt12_slot_sched.sv
// jt12_slot_sched: 24-slot operator scheduler with channel-6 PCM (DAC) sample buffering
// ports: clk_en advances one slot; sN_enters/slot/ch/ch6op/cyc_start describe the current slot;
// pcm_wr/pcm_din feed the PCM buffer, pcm/pcm_en/pcm_underrun are updated at the consume slot (11).
// JT12_PCM_FIFO_EN selects a 2-entry PCM FIFO instead of the single-entry buffer.
module jt12_slot_sched import jt12_sched_pkg::*; #(parameter int PCM_W = 9) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             pcm_en_cfg,
  input  logic             pcm_wr,
  input  logic [PCM_W-1:0] pcm_din,
  output logic             pcm_full,
  output logic             s1_enters,
  output logic             s2_enters,
  output logic             s3_enters,
  output logic             s4_enters,
  output logic [4:0]       slot,
  output logic [2:0]       ch,
  output logic             ch6op,
  output logic [PCM_W-1:0] pcm,
  output logic             pcm_en,
  output logic             pcm_underrun,
  output logic             cyc_start
);
  logic [4:0] nslot;
  grp_e ngrp;
  logic consume, rd, empty;
  logic [PCM_W-1:0] dout;
  // slot-derived outputs are registered from the next slot so they always match slot
  always_comb begin
    nslot   = !clk_en ? slot : slot == 5'(SLOTS - 1) ? 5'd0 : slot + 5'd1;
    ngrp    = grp_of(nslot);
    consume = clk_en && slot == 5'(CONSUME_SLOT);
    // the DAC mode being latched at this consume also decides whether this consume pops
    rd      = consume && pcm_en_cfg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot         <= 5'd0;
      s1_enters    <= 1'b1;
      s2_enters    <= 1'b0;
      s3_enters    <= 1'b0;
      s4_enters    <= 1'b0;
      ch           <= 3'd0;
      ch6op        <= 1'b0;
      cyc_start    <= 1'b1;
      pcm          <= {1'b1, {(PCM_W-1){1'b0}}};
      pcm_en       <= 1'b0;
      pcm_underrun <= 1'b0;
    end else begin
      slot         <= nslot;
      s1_enters    <= ngrp == GRP_S1;
      s2_enters    <= ngrp == GRP_S2;
      s3_enters    <= ngrp == GRP_S3;
      s4_enters    <= ngrp == GRP_S4;
      ch           <= 3'(nslot % 5'(CHANNELS));
      ch6op        <= nslot % 5'(CHANNELS) == 5'(CHANNELS - 1);
      cyc_start    <= nslot == 5'd0;
      pcm_underrun <= rd && empty;
      if (rd && !empty) pcm <= dout;
      if (consume) pcm_en <= pcm_en_cfg;
    end
  end
  jt12_pcm_buf #(.PCM_W(PCM_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (pcm_wr),
    .rd    (rd),
    .din   (pcm_din),
    .dout  (dout),
    .full  (pcm_full),
    .empty (empty)
  );
endmodule

// File: tb/tb_jt12_slot_sched.sv
// tb_jt12_slot_sched: directed + randomized checks of jt12_slot_sched against a queue-based model
module tb_jt12_slot_sched;
`ifdef JT12_PCM_FIFO_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 0, rst = 1, clk_en = 0, pcm_en_cfg = 0, pcm_wr = 0;
  logic [8:0] pcm_din = 0;
  logic pcm_full, s1_enters, s2_enters, s3_enters, s4_enters, ch6op, pcm_en, pcm_underrun, cyc_start;
  logic [4:0] slot;
  logic [2:0] ch;
  logic [8:0] pcm;
  int n_cmp = 0, n_bad = 0;
  bit go = 0;
  int mslot = 0;
  logic [8:0] q[$];
  logic [8:0] mpcm = 9'h100;
  bit men = 0, mund = 0;
  jt12_slot_sched #(.PCM_W(9)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .pcm_en_cfg(pcm_en_cfg), .pcm_wr(pcm_wr),
    .pcm_din(pcm_din), .pcm_full(pcm_full), .s1_enters(s1_enters), .s2_enters(s2_enters),
    .s3_enters(s3_enters), .s4_enters(s4_enters), .slot(slot), .ch(ch), .ch6op(ch6op),
    .pcm(pcm), .pcm_en(pcm_en), .pcm_underrun(pcm_underrun), .cyc_start(cyc_start)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference behaviour: slot counter mod 24, FIFO queue of at most DEPTH samples
  task automatic model_step();
    bit consume, pop;
    if (rst) begin
      mslot = 0; q.delete(); mpcm = 9'h100; men = 0; mund = 0;
    end else begin
      consume = clk_en && mslot == 11;
      pop = consume && pcm_en_cfg;
      mund = 0;
      if (pop) begin
        if (q.size() > 0) mpcm = q.pop_front();
        else mund = 1;
      end
      if (pcm_wr && q.size() < DEPTH) q.push_back(pcm_din);
      if (consume) men = pcm_en_cfg;
      if (clk_en) mslot = (mslot + 1) % 24;
    end
  endtask
  task automatic tick();
    #1;
    model_step();
    if (rst) go = 1;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_to_consume();
    int n = 0;
    clk_en = 1;
    while (mslot != 11 && n < 40) begin
      tick();
      n++;
    end
    chk("reach_consume", slot, 11);
  endtask
  always @(negedge clk) if (go) begin
    int g;
    g = mslot / 6;
    chk("slot", slot, mslot);
    chk("s1_enters", s1_enters, g == 0);
    chk("s3_enters", s3_enters, g == 1);
    chk("s2_enters", s2_enters, g == 2);
    chk("s4_enters", s4_enters, g == 3);
    chk("ch", ch, mslot % 6);
    chk("ch6op", ch6op, mslot % 6 == 5);
    chk("cyc_start", cyc_start, mslot == 0);
    chk("pcm", pcm, mpcm);
    chk("pcm_en", pcm_en, men);
    chk("pcm_underrun", pcm_underrun, mund);
    chk("pcm_full", pcm_full, q.size() == DEPTH);
  end
  initial begin
    int s3cnt, c6cnt, rate;
    rst = 1;
    tick();
    tick();
    chk("rst_slot", slot, 0);
    chk("rst_s1", s1_enters, 1);
    chk("rst_s3", s3_enters, 0);
    chk("rst_ch6op", ch6op, 0);
    chk("rst_cyc_start", cyc_start, 1);
    chk("rst_pcm", pcm, 9'h100);
    chk("rst_full", pcm_full, 0);
    rst = 0;
    clk_en = 1;
    s3cnt = 0;
    c6cnt = 0;
    repeat (48) begin
      tick();
      if (s3_enters) s3cnt++;
      if (ch6op) c6cnt++;
    end
    chk("s3_count", s3cnt, 12);
    chk("ch6op_count", c6cnt, 8);
    chk("wrap_slot", slot, 0);
    clk_en = 1; tick(); chk("toggle_slot1", slot, 1);
    clk_en = 0; tick(); chk("toggle_hold1", slot, 1); chk("toggle_s1_hold", s1_enters, 1);
    clk_en = 1; tick(); chk("toggle_slot2", slot, 2);
    clk_en = 0; tick(); chk("toggle_hold2", slot, 2);
    pcm_en_cfg = 1;
    pcm_wr = 1; pcm_din = 9'h1A5; tick(); pcm_wr = 0;
    chk("wr_full", pcm_full, DEPTH == 1);
    run_to_consume();
    tick();
    chk("consume_pcm", pcm, 9'h1A5);
    chk("consume_full_clear", pcm_full, 0);
    chk("consume_no_underrun", pcm_underrun, 0);
    run_to_consume();
    tick();
    chk("underrun_hold", pcm, 9'h1A5);
    chk("underrun_pulse", pcm_underrun, 1);
    clk_en = 0; tick();
    chk("underrun_one_clk", pcm_underrun, 0);
    for (int i = 0; i < DEPTH; i++) begin
      pcm_wr = 1; pcm_din = 9'(9'h055 + i * 9'h011); tick();
    end
    pcm_wr = 0;
    chk("fill_full", pcm_full, 1);
    run_to_consume();
    pcm_wr = 1; pcm_din = 9'h0FF; tick(); pcm_wr = 0;
    chk("full_consume_pcm", pcm, 9'h055);
    chk("full_consume_keep", pcm_full, 1);
    run_to_consume();
    tick();
    chk("no_drop_next", pcm, DEPTH == 2 ? 9'h066 : 9'h0FF);
`ifdef JT12_PCM_FIFO_EN
    rst = 1; tick(); rst = 0; clk_en = 0;
    pcm_wr = 1; pcm_din = 9'h010; tick();
    pcm_din = 9'h020; tick();
    pcm_wr = 0;
    chk("fifo_full", pcm_full, 1);
    pcm_wr = 1; pcm_din = 9'h030; tick(); pcm_wr = 0;
    run_to_consume(); tick(); chk("fifo_first", pcm, 9'h010);
    run_to_consume(); tick(); chk("fifo_second", pcm, 9'h020);
    run_to_consume(); tick(); chk("fifo_dropped", pcm_underrun, 1);
`endif
    clk_en = 0; pcm_wr = 1; pcm_din = 9'h0AA; tick();
    rst = 1; pcm_wr = 1; clk_en = 1; tick();
    rst = 0; pcm_wr = 0; clk_en = 0;
    chk("rst_prio_full", pcm_full, 0);
    chk("rst_prio_slot", slot, 0);
    chk("rst_prio_pcm", pcm, 9'h100);
    repeat (8) begin
      rate = $urandom_range(1, 60);
      repeat (500) begin
        rst = $urandom_range(0, 299) == 0;
        clk_en = $urandom_range(0, 3) != 0;
        pcm_wr = $urandom_range(0, rate - 1) == 0;
        pcm_din = 9'($urandom);
        if ($urandom_range(0, 99) == 0) pcm_en_cfg = ~pcm_en_cfg;
        tick();
      end
    end
    rst = 0; clk_en = 0; pcm_wr = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
